serial_word_receiver: RTL and testbench

- Serial-to-parallel receiving end of the 16-bit shift-register link: takes the single-bit stream produced by the shifting register's last-stage output and rebuilds parallel words.
- Frame is opened by a start strobe. Bits are qualified by a strobe. Bit order is selectable to match left or right shift.
- Completed words are presented on a registered output with a valid/ready handshake. Sits between the link and the consuming datapath.

---
 rtl/serial_word_receiver_pkg.sv | 19 +
 rtl/serial_word_shifter.sv | 73 +++++++
 rtl/serial_word_receiver.sv | 145 ++++++++++++++
 tb/tb_serial_word_receiver.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/serial_word_receiver_pkg.sv
// Shared types and constants for the serial word receiver.
// The optional parity feature is enabled with SERIAL_WORD_RECEIVER_PARITY_EN.
package serial_word_receiver_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int   DEFAULT_WIDTH = 16;
    localparam logic DIR_LSB_FIRST = 1'b0;
    localparam logic DIR_MSB_FIRST = 1'b1;

    // Even-parity bit for a zero-extended word: 1 when the number of set bits is odd.
    function automatic logic even_parity(input logic [31:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/serial_word_shifter.sv
// Direction-selectable shift register with a bit counter.
// Only the first WIDTH accepted bits of a frame are shifted in; any later bit is only counted.
module serial_word_shifter
    import serial_word_receiver_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    input  logic             dir,
    input  logic             serial_in,
    output logic [WIDTH-1:0] data_word,
    output logic [CNT_W-1:0] bit_count
);

    logic [WIDTH-1:0] shift_reg_r;
    logic [WIDTH-1:0] shift_next_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_next_s;
    logic             in_data_s;

    function automatic logic [WIDTH-1:0] shift_one(input logic [WIDTH-1:0] cur,
                                                   input logic             d,
                                                   input logic             msb);
        if (msb == DIR_MSB_FIRST) begin
            return {cur[WIDTH-2:0], d};
        end else begin
            return {d, cur[WIDTH-1:1]};
        end
    endfunction

    // data_word is the data as it stands once this cycle's bit is taken, so the
    // top level can capture a completed word on the same edge the last bit arrives.
    assign in_data_s = (cnt_r < CNT_W'(WIDTH));
    assign data_word = in_data_s ? shift_one(shift_reg_r, serial_in, dir) : shift_reg_r;
    assign bit_count = cnt_r;

    // Next shift-register and counter values; clear with enable starts a new frame on this bit.
    always_comb begin
        shift_next_s = shift_reg_r;
        cnt_next_s   = cnt_r;
        if (clear) begin
            if (enable) begin
                shift_next_s = shift_one({WIDTH{1'b0}}, serial_in, dir);
                cnt_next_s   = CNT_W'(1);
            end else begin
                shift_next_s = {WIDTH{1'b0}};
                cnt_next_s   = {CNT_W{1'b0}};
            end
        end else if (enable) begin
            shift_next_s = data_word;
            cnt_next_s   = cnt_r + CNT_W'(1);
        end else begin
            shift_next_s = shift_reg_r;
            cnt_next_s   = cnt_r;
        end
    end

    // Shift register and counter state.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_reg_r <= {WIDTH{1'b0}};
            cnt_r       <= {CNT_W{1'b0}};
        end else begin
            shift_reg_r <= shift_next_s;
            cnt_r       <= cnt_next_s;
        end
    end

endmodule

// File: rtl/serial_word_receiver.sv
// Serial-to-parallel receiver: frames a qualified bit stream into words with a valid/ready output.
// Define SERIAL_WORD_RECEIVER_PARITY_EN for a trailing even-parity bit and the parity_err output.
module serial_word_receiver
    import serial_word_receiver_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
`ifdef SERIAL_WORD_RECEIVER_PARITY_EN
    parameter int CNT_W = $clog2(WIDTH + 2)
`else
    parameter int CNT_W = $clog2(WIDTH + 1)
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             serial_in,
    input  logic             bit_valid,
    input  logic             start,
    input  logic             msb_first,
    output logic [WIDTH-1:0] word_out,
    output logic             word_valid,
    input  logic             word_ready,
    output logic             busy,
    output logic [CNT_W-1:0] bit_count,
    output logic             overrun
`ifdef SERIAL_WORD_RECEIVER_PARITY_EN
    ,
    output logic             parity_err
`endif
);

`ifdef SERIAL_WORD_RECEIVER_PARITY_EN
    localparam int FRAME_LEN = WIDTH + 1;
`else
    localparam int FRAME_LEN = WIDTH;
`endif
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

    state_t           state_r;
    state_t           state_next_s;
    logic             dir_r;
    logic             dir_s;
    logic             clear_s;
    logic             enable_s;
    logic             done_s;
    logic [WIDTH-1:0] data_word_s;
    logic [CNT_W-1:0] bit_count_s;
    logic [WIDTH-1:0] word_out_r;
    logic             word_valid_r;
    logic             overrun_r;
`ifdef SERIAL_WORD_RECEIVER_PARITY_EN
    logic             parity_err_r;
`endif

    serial_word_shifter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_shifter (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear_s),
        .enable    (enable_s),
        .dir       (dir_s),
        .serial_in (serial_in),
        .data_word (data_word_s),
        .bit_count (bit_count_s)
    );

    // Frame control: start (re)opens a frame from either state; the last bit closes it.
    always_comb begin
        state_next_s = state_r;
        dir_s        = dir_r;
        clear_s      = 1'b0;
        enable_s     = 1'b0;
        done_s       = 1'b0;
        if (start) begin
            state_next_s = SHIFT;
            dir_s        = msb_first;
            clear_s      = 1'b1;
            enable_s     = bit_valid;
        end else begin
            case (state_r)
                IDLE: begin
                    state_next_s = IDLE;
                end
                SHIFT: begin
                    if (bit_valid) begin
                        if (bit_count_s == LAST_IDX) begin
                            done_s       = 1'b1;
                            clear_s      = 1'b1;
                            state_next_s = IDLE;
                        end else begin
                            enable_s     = 1'b1;
                        end
                    end else begin
                        state_next_s = SHIFT;
                    end
                end
                default: begin
                    state_next_s = IDLE;
                end
            endcase
        end
    end

    // State, latched direction, output buffer and handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            dir_r        <= DIR_MSB_FIRST;
            word_out_r   <= {WIDTH{1'b0}};
            word_valid_r <= 1'b0;
            overrun_r    <= 1'b0;
`ifdef SERIAL_WORD_RECEIVER_PARITY_EN
            parity_err_r <= 1'b0;
`endif
        end else begin
            state_r <= state_next_s;
            dir_r   <= dir_s;
            if (done_s && (!word_valid_r || word_ready)) begin
                word_out_r   <= data_word_s;
                word_valid_r <= 1'b1;
`ifdef SERIAL_WORD_RECEIVER_PARITY_EN
                // On the closing cycle serial_in carries the parity bit.
                parity_err_r <= even_parity(32'(data_word_s)) ^ serial_in;
`endif
            end else if (done_s) begin
                overrun_r <= 1'b1;
            end else if (word_valid_r && word_ready) begin
                word_valid_r <= 1'b0;
            end else begin
                word_valid_r <= word_valid_r;
            end
        end
    end

    assign word_out   = word_out_r;
    assign word_valid = word_valid_r;
    assign overrun    = overrun_r;
    assign busy       = (state_r == SHIFT);
    assign bit_count  = bit_count_s;
`ifdef SERIAL_WORD_RECEIVER_PARITY_EN
    assign parity_err = parity_err_r;
`endif

endmodule

// File: tb/tb_serial_word_receiver.sv
// Directed bench for serial_word_receiver: table of whole frames plus hand-written corner sequences.
// Covers the SERIAL_WORD_RECEIVER_PARITY_EN build as well when that macro is defined.
module tb_serial_word_receiver;

    localparam int WIDTH = 16;
`ifdef SERIAL_WORD_RECEIVER_PARITY_EN
    localparam int CNT_W = $clog2(WIDTH + 2);
    localparam int FRAME = WIDTH + 1;
`else
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int FRAME = WIDTH;
`endif

    logic             clk;
    logic             rst;
    logic             serial_in;
    logic             bit_valid;
    logic             start;
    logic             msb_first;
    logic [WIDTH-1:0] word_out;
    logic             word_valid;
    logic             word_ready;
    logic             busy;
    logic [CNT_W-1:0] bit_count;
    logic             overrun;
`ifdef SERIAL_WORD_RECEIVER_PARITY_EN
    logic             parity_err;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    serial_word_receiver #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .serial_in  (serial_in),
        .bit_valid  (bit_valid),
        .start      (start),
        .msb_first  (msb_first),
        .word_out   (word_out),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .busy       (busy),
        .bit_count  (bit_count),
        .overrun    (overrun)
`ifdef SERIAL_WORD_RECEIVER_PARITY_EN
        ,
        .parity_err (parity_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        do_rst;
        logic [15:0] stream;
        logic        msb;
        logic        gap;
        logic        ready_last;
        logic        lat;
        logic        consume;
        logic [15:0] exp_word;
        logic        exp_ovr;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_rst();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic do_start(input logic msb);
        start     = 1'b1;
        msb_first = msb;
        bit_valid = 1'b0;
        tick();
        start = 1'b0;
        check("start_busy", 32'(busy), 32'd1);
        check("start_count", 32'(bit_count), 32'd0);
    endtask

    // Stream bits go out stream[15] first; with parity a trailing parity bit follows.
    task automatic send_frame(input logic [15:0] stream, input logic msb, input logic gap,
                              input logic ready_last, input logic lat, input logic par_bad);
        logic b;
        do_start(msb);
        for (int n = 1; n <= FRAME; n++) begin
            if (n <= 16) b = stream[16 - n];
            else         b = (^stream) ^ par_bad;
            serial_in  = b;
            bit_valid  = 1'b1;
            word_ready = (n == FRAME) ? ready_last : 1'b0;
            if (lat && n == FRAME) check("valid_before_last", 32'(word_valid), 32'd0);
            tick();
            check("bit_count_step", 32'(bit_count), (n == FRAME) ? 32'd0 : 32'(n));
            if (gap && n < FRAME) begin
                bit_valid = 1'b0;
                serial_in = ~b;
                tick();
                check("bit_count_gap", 32'(bit_count), 32'(n));
            end
        end
        bit_valid  = 1'b0;
        word_ready = 1'b0;
        check("frame_end_busy", 32'(busy), 32'd0);
    endtask

    task automatic send_raw(input logic [15:0] stream, input int nbits);
        for (int k = 0; k < nbits; k++) begin
            serial_in = stream[15 - k];
            bit_valid = 1'b1;
            tick();
        end
        bit_valid = 1'b0;
    endtask

    task automatic consume_word();
        word_ready = 1'b1;
        tick();
        word_ready = 1'b0;
        check("consume_valid", 32'(word_valid), 32'd0);
    endtask

    initial begin
        rst        = 1'b1;
        serial_in  = 1'b0;
        bit_valid  = 1'b0;
        start      = 1'b0;
        msb_first  = 1'b0;
        word_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        check("rst_word_out", 32'(word_out), 32'h0);
        check("rst_word_valid", 32'(word_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_bit_count", 32'(bit_count), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
`ifdef SERIAL_WORD_RECEIVER_PARITY_EN
        check("rst_parity_err", 32'(parity_err), 32'd0);
`endif

        // Bits in IDLE without start must be ignored.
        serial_in = 1'b1;
        bit_valid = 1'b1;
        tick();
        tick();
        bit_valid = 1'b0;
        check("idle_bits_count", 32'(bit_count), 32'd0);
        check("idle_bits_busy", 32'(busy), 32'd0);

        //            rst   stream     msb   gap   rdy   lat   cons  expected  ovr
        vecs[0] = '{1'b1, 16'hA5C3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'hA5C3, 1'b0};
        vecs[1] = '{1'b0, 16'hA5C3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'hC3A5, 1'b0};
        vecs[2] = '{1'b0, 16'h1234, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 16'h1234, 1'b0};
        vecs[3] = '{1'b0, 16'h00FF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h00FF, 1'b0};
        vecs[4] = '{1'b0, 16'hFF00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h00FF, 1'b1};
        vecs[5] = '{1'b0, 16'hFF00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'hFF00, 1'b1};

        for (int i = 0; i < 6; i++) begin
            if (vecs[i].do_rst) apply_rst();
            send_frame(vecs[i].stream, vecs[i].msb, vecs[i].gap, vecs[i].ready_last,
                       vecs[i].lat, 1'b0);
            check("vec_word_out", 32'(word_out), 32'(vecs[i].exp_word));
            check("vec_word_valid", 32'(word_valid), 32'd1);
            check("vec_overrun", 32'(overrun), 32'(vecs[i].exp_ovr));
`ifdef SERIAL_WORD_RECEIVER_PARITY_EN
            check("vec_parity_err", 32'(parity_err), 32'd0);
`endif
            if (vecs[i].consume) consume_word();
        end

        // Restart after 7 bits: partial frame discarded, no overrun.
        apply_rst();
        do_start(1'b1);
        send_raw(16'hFFFF, 7);
        check("partial_count", 32'(bit_count), 32'd7);
        check("partial_valid", 32'(word_valid), 32'd0);
        send_frame(16'hBEEF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        check("restart_word", 32'(word_out), 32'hBEEF);
        check("restart_valid", 32'(word_valid), 32'd1);
        check("restart_overrun", 32'(overrun), 32'd0);

        // Reset mid-frame after 9 bits clears everything, then stray bits stay ignored.
        do_start(1'b0);
        send_raw(16'hFFFF, 9);
        check("midrst_pre_busy", 32'(busy), 32'd1);
        check("midrst_pre_count", 32'(bit_count), 32'd9);
        apply_rst();
        check("midrst_word_out", 32'(word_out), 32'h0);
        check("midrst_valid", 32'(word_valid), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_count", 32'(bit_count), 32'd0);
        check("midrst_overrun", 32'(overrun), 32'd0);
        send_raw(16'hFFFF, 7);
        check("midrst_after_count", 32'(bit_count), 32'd0);
        check("midrst_after_valid", 32'(word_valid), 32'd0);

`ifdef SERIAL_WORD_RECEIVER_PARITY_EN
        send_frame(16'h0001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("parity_good_word", 32'(word_out), 32'h0001);
        check("parity_good_err", 32'(parity_err), 32'd0);
        consume_word();
        send_frame(16'h0001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        check("parity_bad_word", 32'(word_out), 32'h0001);
        check("parity_bad_err", 32'(parity_err), 32'd1);
        // A dropped word leaves parity_err untouched.
        send_frame(16'h0003, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("parity_drop_err", 32'(parity_err), 32'd1);
        check("parity_drop_overrun", 32'(overrun), 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
